// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding
// and the binary-to-Gray index mapping.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } tt_state_e;

    // Widest index the sweeper supports (N_IN up to 8, plus the terminal bit).
    localparam int unsigned TT_IDX_W = 9;

    function automatic logic [TT_IDX_W-1:0] bin2gray(input logic [TT_IDX_W-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper, its start/done controller and the pair of DUTs
// under comparison.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3,
    parameter int N_CH = 1
);
    logic            start;
    logic            abort;
    logic [N_IN-1:0] vec;
    logic [N_CH-1:0] resp_a;
    logic [N_CH-1:0] resp_b;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_CH-1:0] err_mask;
    logic [N_IN-1:0] first_vec;
    logic            first_valid;

    // Controller plus the two implementations being compared.
    modport master (
        output start, abort, resp_a, resp_b,
        input  vec, busy, done, pass, err_cnt, err_mask, first_vec, first_valid
    );

    modport slave (
        input  start, abort, resp_a, resp_b,
        output vec, busy, done, pass, err_cnt, err_mask, first_vec, first_valid
    );
endinterface

// File: rtl/tt_result_acc.sv
// Result accumulator for the sweeper: mismatch count, OR of failing channels
// and capture of the first failing vector.
module tt_result_acc #(
    parameter int N_IN = 3,
    parameter int N_CH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            valid,
    input  logic [N_CH-1:0] diff,
    input  logic [N_IN-1:0] vec,
    output logic [N_IN:0]   err_cnt,
    output logic [N_CH-1:0] err_mask,
    output logic [N_IN-1:0] first_vec,
    output logic            first_valid
);

    logic [N_IN:0]   err_cnt_r;
    logic [N_CH-1:0] err_mask_r;
    logic [N_IN-1:0] first_vec_r;
    logic            first_valid_r;

    // Accumulate per-vector diffs; the count cannot wrap since it holds 2^N_IN.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_cnt_r     <= '0;
            err_mask_r    <= '0;
            first_vec_r   <= '0;
            first_valid_r <= 1'b0;
        end else if (valid && (diff != '0)) begin
            err_cnt_r  <= err_cnt_r + (N_IN+1)'(1);
            err_mask_r <= err_mask_r | diff;
            if (!first_valid_r) begin
                first_vec_r   <= vec;
                first_valid_r <= 1'b1;
            end
        end
    end

    assign err_cnt     = err_cnt_r;
    assign err_mask    = err_mask_r;
    assign first_vec   = first_vec_r;
    assign first_valid = first_valid_r;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive equivalence sweeper: steps every input vector into two
// implementations, holds it SETTLE clocks, then compares their responses.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_CH   = 1,
    parameter int SETTLE = 1,
    parameter int GRAY   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweeper_if.slave bus
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [N_IN:0] IDX_LAST    = (N_IN+1)'((1 << N_IN) - 1);

    tt_state_e       state_r, state_n;
    logic [N_IN:0]   idx_r, idx_n;
    logic [SW-1:0]   settle_r, settle_n;
    logic [N_IN-1:0] vec_r, vec_n;
    logic            busy_r, busy_n;
    logic            done_r, done_n;
    logic            pass_r, pass_n;

    logic [N_CH-1:0] diff_s;
    logic            clear_s;
    logic            cmp_valid_s;
    logic            cnt_zero_s;
    logic [N_IN:0]   err_cnt_s;

    function automatic logic [N_IN-1:0] vec_of(input logic [N_IN:0] i);
        if (GRAY != 0) begin
            return N_IN'(bin2gray(TT_IDX_W'(i)));
        end else begin
            return N_IN'(i);
        end
    endfunction

    assign diff_s = bus.resp_a ^ bus.resp_b;
    // A mismatch on the final compare must already veto pass as DONE is entered.
    assign cnt_zero_s = (err_cnt_s == '0) && !(cmp_valid_s && (diff_s != '0));

    // Next-state, index/settle counters and registered output values.
    always_comb begin
        state_n     = state_r;
        idx_n       = idx_r;
        settle_n    = settle_r;
        vec_n       = vec_r;
        clear_s     = 1'b0;
        cmp_valid_s = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_n  = DRIVE;
                        idx_n    = '0;
                        settle_n = SETTLE_INIT;
                        vec_n    = vec_of((N_IN+1)'(0));
                        clear_s  = 1'b1;
                    end else begin
                        state_n = state_r;
                    end
                end
                DRIVE: begin
                    if (settle_r == SW'(0)) begin
                        state_n = COMPARE;
                    end else begin
                        settle_n = settle_r - SW'(1);
                    end
                end
                COMPARE: begin
                    cmp_valid_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n  = DRIVE;
                        idx_n    = idx_r + (N_IN+1)'(1);
                        settle_n = SETTLE_INIT;
                        vec_n    = vec_of(idx_r + (N_IN+1)'(1));
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        busy_n = (state_n == DRIVE) || (state_n == COMPARE);
        done_n = (state_n == DONE);
        pass_n = done_n && cnt_zero_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            settle_r <= '0;
            vec_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            idx_r    <= idx_n;
            settle_r <= settle_n;
            vec_r    <= vec_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            pass_r   <= pass_n;
        end
    end

    tt_result_acc #(
        .N_IN(N_IN),
        .N_CH(N_CH)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .valid      (cmp_valid_s),
        .diff       (diff_s),
        .vec        (vec_r),
        .err_cnt    (err_cnt_s),
        .err_mask   (bus.err_mask),
        .first_vec  (bus.first_vec),
        .first_valid(bus.first_valid)
    );

    assign bus.vec     = vec_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.err_cnt = err_cnt_s;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (binary/SETTLE=1/2 channels and
// Gray/SETTLE=3/1 channel) driven by lookup-table "implementations".
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(3), .N_CH(2)) if0 ();
    truth_table_sweeper_if #(.N_IN(3), .N_CH(1)) if1 ();

    truth_table_sweeper #(.N_IN(3), .N_CH(2), .SETTLE(1), .GRAY(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    truth_table_sweeper #(.N_IN(3), .N_CH(1), .SETTLE(3), .GRAY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    logic [1:0] ta0 [8];
    logic [1:0] tb0 [8];
    logic       ta1 [8];
    logic       tb1 [8];

    assign if0.resp_a = ta0[if0.vec];
    assign if0.resp_b = tb0[if0.vec];
    assign if1.resp_a = ta1[if1.vec];
    assign if1.resp_b = tb1[if1.vec];

    int n_cmp = 0;
    int n_err = 0;
    int order [2][8];
    int span  [2] = '{2, 4};
    int e_cnt, e_mask, e_first;
    int e_fv;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // sel: 0 vec, 1 busy, 2 done, 3 pass, 4 err_cnt, 5 err_mask, 6 first_vec, 7 first_valid
    function automatic logic [31:0] obs(input int d, input int sel);
        if (d == 0) begin
            case (sel)
                0: return 32'(if0.vec);
                1: return 32'(if0.busy);
                2: return 32'(if0.done);
                3: return 32'(if0.pass);
                4: return 32'(if0.err_cnt);
                5: return 32'(if0.err_mask);
                6: return 32'(if0.first_vec);
                default: return 32'(if0.first_valid);
            endcase
        end else begin
            case (sel)
                0: return 32'(if1.vec);
                1: return 32'(if1.busy);
                2: return 32'(if1.done);
                3: return 32'(if1.pass);
                4: return 32'(if1.err_cnt);
                5: return 32'(if1.err_mask);
                6: return 32'(if1.first_vec);
                default: return 32'(if1.first_valid);
            endcase
        end
    endfunction

    task automatic set_in(input int d, input logic st, input logic ab);
        if (d == 0) begin
            if0.start = st;
            if0.abort = ab;
        end else begin
            if1.start = st;
            if1.abort = ab;
        end
    endtask

    // Expected results after the first n vectors of the sweep order.
    task automatic model(input int d, input int n);
        int v, df;
        e_cnt = 0; e_mask = 0; e_first = 0; e_fv = 0;
        for (int k = 0; k < n; k++) begin
            v  = order[d][k];
            df = (d == 0) ? int'(ta0[v] ^ tb0[v]) : int'(ta1[v] ^ tb1[v]);
            if (df != 0) begin
                e_cnt++;
                e_mask |= df;
                if (e_fv == 0) begin
                    e_first = v;
                    e_fv    = 1;
                end
            end
        end
    endtask

    // flip_pct: chance (percent) that B differs from A at a vector.
    task automatic rand_tables(input int d, input int flip_pct);
        for (int v = 0; v < 8; v++) begin
            if (d == 0) begin
                ta0[v] = 2'($urandom);
                tb0[v] = ta0[v] ^ (($urandom_range(99) < flip_pct) ? 2'($urandom_range(3, 1)) : 2'b00);
            end else begin
                ta1[v] = 1'($urandom);
                tb1[v] = ta1[v] ^ ($urandom_range(99) < flip_pct);
            end
        end
    endtask

    task automatic check_final(input int d, input string t);
        chk({t, "_done"}, obs(d, 2), 32'd1);
        chk({t, "_busy"}, obs(d, 1), 32'd0);
        chk({t, "_pass"}, obs(d, 3), 32'(e_cnt == 0));
        chk({t, "_cnt"},  obs(d, 4), 32'(e_cnt));
        chk({t, "_mask"}, obs(d, 5), 32'(e_mask));
        chk({t, "_first"}, obs(d, 6), 32'(e_first));
        chk({t, "_fv"},   obs(d, 7), 32'(e_fv));
        chk({t, "_vec"},  obs(d, 0), 32'(order[d][7]));
    endtask

    // Full sweep from a start pulse, checking vec/busy/done every clock.
    task automatic sweep(input int d, input bit poke, input string t);
        int total;
        logic [31:0] prev;
        total = 8 * span[d];
        model(d, 8);
        set_in(d, 1'b1, 1'b0);
        @(negedge clk);
        set_in(d, 1'b0, 1'b0);
        chk({t, "_clr_cnt"}, obs(d, 4), 32'd0);
        chk({t, "_clr_fv"},  obs(d, 7), 32'd0);
        prev = obs(d, 0);
        for (int c = 0; c < total; c++) begin
            chk({t, "_vec"},  obs(d, 0), 32'(order[d][c / span[d]]));
            chk({t, "_busy"}, obs(d, 1), 32'd1);
            chk({t, "_done_early"}, obs(d, 2), 32'd0);
            if (d == 1 && c > 0 && (c % span[d]) == 0)
                chk({t, "_gray_step"}, 32'($countones(obs(d, 0) ^ prev)), 32'd1);
            prev = obs(d, 0);
            set_in(d, poke && (c == 3), 1'b0);
            @(negedge clk);
        end
        set_in(d, 1'b0, 1'b0);
        check_final(d, t);
    endtask

    initial begin
        int g [$];
        int m;
        for (int k = 0; k < 8; k++) order[0][k] = k;
        g = {0};
        for (int b = 0; b < 3; b++) begin
            m = g.size();
            for (int j = m - 1; j >= 0; j--) g.push_back(g[j] | (1 << b));
        end
        for (int k = 0; k < 8; k++) order[1][k] = g[k];

        rand_tables(0, 0);
        rand_tables(1, 0);
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            chk("rst0", obs(0, s), 32'd0);
            chk("rst1", obs(1, s), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Identical implementations, then single-point and whole-channel faults.
        sweep(0, 1'b0, "same0");
        tb0[5] = ta0[5] ^ 2'b01;
        sweep(0, 1'b1, "v5");
        for (int v = 0; v < 8; v++) tb0[v] = ta0[v] ^ 2'b10;
        sweep(0, 1'b0, "bit1");
        for (int i = 0; i < 3; i++) begin
            rand_tables(0, 30);
            sweep(0, i[0], "rnd0");
        end

        // Gray order, SETTLE=3; the second sweep restarts from DONE.
        sweep(1, 1'b0, "gray_same");
        rand_tables(1, 40);
        sweep(1, 1'b1, "gray_rnd");
        rand_tables(1, 40);
        sweep(1, 1'b0, "gray_redo");

        // Abort after three vectors are compared (two mismatches).
        rand_tables(0, 50);
        tb0[0] = ta0[0];
        tb0[1] = ta0[1] ^ 2'b01;
        tb0[2] = ta0[2] ^ 2'b11;
        model(0, 3);
        set_in(0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        set_in(0, 1'b0, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        chk("abort_busy",  obs(0, 1), 32'd0);
        chk("abort_done",  obs(0, 2), 32'd0);
        chk("abort_pass",  obs(0, 3), 32'd0);
        chk("abort_cnt",   obs(0, 4), 32'(e_cnt));
        chk("abort_mask",  obs(0, 5), 32'(e_mask));
        chk("abort_first", obs(0, 6), 32'(e_first));
        chk("abort_fv",    obs(0, 7), 32'(e_fv));
        chk("abort_vec",   obs(0, 0), 32'(order[0][3]));
        @(negedge clk);
        chk("abort_idle",  obs(0, 1), 32'd0);
        set_in(0, 1'b1, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        chk("startabort_busy", obs(0, 1), 32'd0);
        chk("startabort_cnt",  obs(0, 4), 32'(e_cnt));
        sweep(0, 1'b0, "after_abort");

        // Reset together with start in the middle of DRIVE.
        set_in(0, 1'b1, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", obs(0, 1), 32'd1);
        set_in(0, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 8; s++) chk("midrst0", obs(0, s), 32'd0);
        reset = 1'b0;
        set_in(0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_idle", obs(0, 1), 32'd0);
        rand_tables(0, 25);
        sweep(0, 1'b0, "final0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
